// File: rtl/keypad_entry_if.sv
// keypad_entry_if
//   Bundles the keypad matrix lines and the decoded entry outputs of
//   keypad_entry into one interface.
//
//   COL        keypad columns, active-low, pulled up off-chip
//   ROW        keypad row drive, exactly one bit low at a time
//   KEY_VALID  one-cycle pulse per accepted key press
//   KEY_CODE   row*4+col of the last accepted key
//   BCD        entered digits, [15:12] thousands .. [3:0] units
//   DATA       binary value of BCD, 0..9999
//
//   master: the keypad_entry block (drives ROW and the entry outputs)
//   slave : keypad matrix / downstream consumer side
interface keypad_entry_if;
    logic [3:0]  COL;
    logic [3:0]  ROW;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic [15:0] BCD;
    logic [15:0] DATA;

    modport master (
        input  COL,
        output ROW,
        output KEY_VALID,
        output KEY_CODE,
        output BCD,
        output DATA
    );

    modport slave (
        output COL,
        input  ROW,
        input  KEY_VALID,
        input  KEY_CODE,
        input  BCD,
        input  DATA
    );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry
//   Scans a 4x4 active-low keypad, debounces presses and releases over
//   whole scan frames, and shifts accepted digits into a 4-digit BCD
//   entry register with CLEAR and BACKSPACE editing. DATA is the binary
//   value of the entry and can drive the seven-segment display directly.
//
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   kp     keypad_entry_if.master: COL in; ROW, KEY_VALID, KEY_CODE,
//          BCD, DATA out
//
//   Parameters
//   SCAN_DIV        CLK cycles each row is driven (>= 2)
//   DEBOUNCE_SCANS  identical frames needed to accept a press/release (>= 1)
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no key held; waiting for a frame with a key
//   DEBOUNCE | candidate key seen, counting identical frames
//   PRESS    | single cycle: pulse KEY_VALID, latch code, apply edit
//   RELEASE  | waiting for DEBOUNCE_SCANS keyless frames in a row
module keypad_entry #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    keypad_entry_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic             hit_q, hit_d;
    logic [3:0]       best_q, best_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [15:0]      data_q, data_d;

    logic             tick;
    logic             frame_close;
    logic             row_hit;
    logic [1:0]       col_idx;
    logic [3:0]       samp_code;
    logic             res_valid;
    logic [3:0]       res_code;
    logic [CNT_W-1:0] cnt_inc;
    logic             is_digit;
    logic [3:0]       digit;
    logic [15:0]      bcd_edit;

    // Scan timing and per-frame result. COL is read directly: the row has
    // been driven for SCAN_DIV-1 cycles before the sample, and a single
    // bad sample cannot survive the frame-level debounce.
    always_comb begin
        tick        = (div_q == DIV_LAST);
        frame_close = tick && (row_q == 2'd3);
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        row_d       = tick ? row_q + 2'd1 : row_q;

        row_hit = (kp.COL != 4'hF);
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!kp.COL[c]) col_idx = 2'(c);
        end
        samp_code = {row_q, col_idx};

        // Rows are visited in ascending order, so the first hit of a frame
        // is already the lowest code; later hits never replace it.
        res_valid = hit_q || row_hit;
        res_code  = hit_q ? best_q : samp_code;

        hit_d  = hit_q;
        best_d = best_q;
        if (frame_close) begin
            hit_d = 1'b0;
        end else if (tick && !hit_q && row_hit) begin
            hit_d  = 1'b1;
            best_d = samp_code;
        end
    end

    // Edit for the candidate key.
    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        case (cand_q)
            4'd0, 4'd1, 4'd2:  begin is_digit = 1'b1; digit = cand_q + 4'd1; end
            4'd4, 4'd5, 4'd6:  begin is_digit = 1'b1; digit = cand_q;        end
            4'd8, 4'd9, 4'd10: begin is_digit = 1'b1; digit = cand_q - 4'd1; end
            4'd13:             begin is_digit = 1'b1; digit = 4'd0;          end
            default:           ;
        endcase

        bcd_edit = bcd_q;
        if (is_digit) begin
            bcd_edit = {bcd_q[11:0], digit};
        end else if (cand_q == 4'd3) begin
            bcd_edit = 16'h0000;
        end else if (cand_q == 4'd7) begin
            bcd_edit = {4'h0, bcd_q[15:4]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_code_d = key_code_q;
        bcd_d      = bcd_q;
        cnt_inc    = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (frame_close && res_valid) begin
                    cand_d  = res_code;
                    cnt_d   = CNT_W'(1);
                    state_d = (CNT_DONE == CNT_W'(1)) ? PRESS : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (frame_close) begin
                    if (!res_valid) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (res_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) state_d = PRESS;
                    end else begin
                        cand_d = res_code;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            // Not frame-gated: a frame close cannot land here because the
            // preceding close is at least a full frame away.
            PRESS: begin
                key_code_d = cand_q;
                bcd_d      = bcd_edit;
                cnt_d      = '0;
                state_d    = RELEASE;
            end
            RELEASE: begin
                if (frame_close) begin
                    if (res_valid) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        data_d = {4'h0, bcd_q[15:12]} * 16'd1000
               + {4'h0, bcd_q[11:8]}  * 16'd100
               + {4'h0, bcd_q[7:4]}   * 16'd10
               + {12'h000, bcd_q[3:0]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            div_q      <= '0;
            row_q      <= 2'd0;
            hit_q      <= 1'b0;
            best_q     <= 4'd0;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            key_code_q <= 4'd0;
            bcd_q      <= 16'h0000;
            data_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            row_q      <= row_d;
            hit_q      <= hit_d;
            best_q     <= best_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_code_q <= key_code_d;
            bcd_q      <= bcd_d;
            data_q     <= data_d;
        end
    end

    assign kp.ROW       = ~(4'b0001 << row_q);
    assign kp.KEY_VALID = (state_q == PRESS);
    assign kp.KEY_CODE  = key_code_q;
    assign kp.BCD       = bcd_q;
    assign kp.DATA      = data_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//   Emulates a 4x4 keypad (held-key mask) against keypad_entry with
//   SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames). A frame-level model
//   tracks debounce, the decimal entry value and expected output timing.
module tb_keypad_entry;

    localparam int SD  = 4;
    localparam int D   = 2;
    localparam int FRM = 4 * SD;

    logic        CLK;
    logic        RST_N;
    logic [15:0] held_mask;
    logic [3:0]  col_drive;

    keypad_entry_if kif ();

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(D)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .kp    (kif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        col_drive = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kif.ROW[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (held_mask[r*4+c]) col_drive[c] = 1'b0;
                end
            end
        end
    end
    assign kif.COL = col_drive;

    int n_checks;
    int n_pass;
    int pulses;

    // model state
    bit         m_lock;
    int         m_rel;
    int         m_skey;
    int         m_sn;
    int         m_val, m_prev_val;
    logic [3:0] m_code, m_prev_code;
    bit         m_pend;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int apply_edit(input int v, input int code);
        case (code)
            0, 1, 2:  return (v * 10 + code + 1) % 10000;
            4, 5, 6:  return (v * 10 + code) % 10000;
            8, 9, 10: return (v * 10 + code - 1) % 10000;
            13:       return (v * 10) % 10000;
            3:        return 0;
            7:        return v / 10;
            default:  return v;
        endcase
    endfunction

    task automatic model_reset();
        m_lock = 0; m_rel = 0; m_skey = 0; m_sn = 0;
        m_val = 0; m_prev_val = 0; m_code = 4'd0; m_prev_code = 4'd0;
        m_pend = 0;
    endtask

    // Runs one frame from a frame-start negedge, checking every cycle.
    task automatic run_frame(input logic [15:0] held);
        int         res;
        logic       exp_kv;
        logic [15:0] exp_bcd, exp_data;
        logic [3:0] exp_code, exp_row;
        held_mask = held;
        for (int off = 0; off < FRM; off++) begin
            exp_kv   = m_pend && (off == 0);
            exp_bcd  = to_bcd((m_pend && off == 0) ? m_prev_val : m_val);
            exp_data = 16'((m_pend && off < 2) ? m_prev_val : m_val);
            exp_code = (m_pend && off == 0) ? m_prev_code : m_code;
            exp_row  = ~(4'b0001 << (off / SD));
            n_checks++;
            if (kif.ROW !== exp_row) $display("FAIL row off=%0d got=%b exp=%b", off, kif.ROW, exp_row);
            else n_pass++;
            n_checks++;
            if (kif.KEY_VALID !== exp_kv) $display("FAIL key_valid off=%0d got=%b exp=%b", off, kif.KEY_VALID, exp_kv);
            else n_pass++;
            n_checks++;
            if (kif.BCD !== exp_bcd) $display("FAIL bcd off=%0d got=%h exp=%h", off, kif.BCD, exp_bcd);
            else n_pass++;
            n_checks++;
            if (kif.DATA !== exp_data) $display("FAIL data off=%0d got=%0d exp=%0d", off, kif.DATA, exp_data);
            else n_pass++;
            n_checks++;
            if (kif.KEY_CODE !== exp_code) $display("FAIL key_code off=%0d got=%0d exp=%0d", off, kif.KEY_CODE, exp_code);
            else n_pass++;
            if (kif.KEY_VALID === 1'b1) pulses++;
            @(negedge CLK);
        end
        m_pend      = 0;
        m_prev_val  = m_val;
        m_prev_code = m_code;
        res = -1;
        for (int k = 15; k >= 0; k--) if (held[k]) res = k;
        if (m_lock) begin
            if (res < 0) begin
                m_rel++;
                if (m_rel == D) begin m_lock = 0; m_sn = 0; end
            end else begin
                m_rel = 0;
            end
        end else begin
            if (res < 0) m_sn = 0;
            else if (m_sn > 0 && res == m_skey) m_sn++;
            else begin m_skey = res; m_sn = 1; end
            if (m_sn == D) begin
                m_lock = 1; m_rel = 0; m_pend = 1;
                m_val  = apply_edit(m_val, res);
                m_code = 4'(res);
            end
        end
    endtask

    task automatic press_key(input int code, input int hold, input int rel);
        repeat (hold) run_frame(16'(1) << code);
        repeat (rel) run_frame(16'h0000);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        held_mask = 16'h0000;
        model_reset();
        repeat (3) @(negedge CLK);
        n_checks++;
        if (kif.ROW !== 4'b1110 || kif.KEY_VALID !== 1'b0 || kif.BCD !== 16'h0 || kif.DATA !== 16'd0 || kif.KEY_CODE !== 4'd0)
            $display("FAIL reset_values row=%b kv=%b bcd=%h data=%0d code=%0d exp row=1110 kv=0 bcd=0 data=0 code=0",
                     kif.ROW, kif.KEY_VALID, kif.BCD, kif.DATA, kif.KEY_CODE);
        else n_pass++;
        RST_N = 1'b1;
        run_frame(16'h0000);
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        press_key(5, 3, 3);
        n_checks++;
        if (pulses - p0 !== 1) $display("FAIL single_pulses got=%0d exp=1", pulses - p0);
        else n_pass++;
        n_checks++;
        if (kif.KEY_CODE !== 4'd5 || kif.BCD !== 16'h0005 || kif.DATA !== 16'd5)
            $display("FAIL single_result code=%0d bcd=%h data=%0d exp 5/0005/5", kif.KEY_CODE, kif.BCD, kif.DATA);
        else n_pass++;
    endtask

    task automatic test_digits();
        int p0;
        int codes[5] = '{0, 1, 2, 4, 5};
        p0 = pulses;
        foreach (codes[i]) press_key(codes[i], 2, 2);
        n_checks++;
        if (pulses - p0 !== 5) $display("FAIL digit_pulses got=%0d exp=5", pulses - p0);
        else n_pass++;
        n_checks++;
        if (kif.BCD !== 16'h2345 || kif.DATA !== 16'd2345)
            $display("FAIL digits_wrap bcd=%h data=%0d exp 2345/2345", kif.BCD, kif.DATA);
        else n_pass++;
        press_key(7, 2, 2);
        n_checks++;
        if (kif.BCD !== 16'h0234 || kif.DATA !== 16'd234)
            $display("FAIL backspace bcd=%h data=%0d exp 0234/234", kif.BCD, kif.DATA);
        else n_pass++;
        press_key(3, 2, 2);
        n_checks++;
        if (kif.BCD !== 16'h0000 || kif.DATA !== 16'd0)
            $display("FAIL clear bcd=%h data=%0d exp 0000/0", kif.BCD, kif.DATA);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        run_frame(16'(1) << 9);
        run_frame(16'h0000);
        n_checks++;
        if (pulses - p0 !== 0) $display("FAIL bounce_early got=%0d exp=0", pulses - p0);
        else n_pass++;
        press_key(9, 2, 2);
        n_checks++;
        if (pulses - p0 !== 1 || kif.BCD !== 16'h0008)
            $display("FAIL bounce pulses=%0d bcd=%h exp 1/0008", pulses - p0, kif.BCD);
        else n_pass++;
    endtask

    task automatic test_multi_key();
        int p0;
        p0 = pulses;
        repeat (5) run_frame((16'(1) << 6) | (16'(1) << 1));
        n_checks++;
        if (pulses - p0 !== 1 || kif.KEY_CODE !== 4'd1 || kif.BCD !== 16'h0082)
            $display("FAIL multi_key pulses=%0d code=%0d bcd=%h exp 1/1/0082", pulses - p0, kif.KEY_CODE, kif.BCD);
        else n_pass++;
        repeat (2) run_frame(16'h0000);
    endtask

    task automatic test_reset_mid();
        int p0;
        press_key(3, 2, 2);
        press_key(4, 2, 2);
        repeat (3) run_frame(16'(1) << 1);
        n_checks++;
        if (kif.BCD !== 16'h0042) $display("FAIL pre_reset bcd=%h exp=0042", kif.BCD);
        else n_pass++;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (kif.BCD !== 16'h0 || kif.DATA !== 16'd0 || kif.ROW !== 4'b1110 || kif.KEY_VALID !== 1'b0 || kif.KEY_CODE !== 4'd0)
            $display("FAIL mid_reset bcd=%h data=%0d row=%b kv=%b code=%0d exp 0/0/1110/0/0",
                     kif.BCD, kif.DATA, kif.ROW, kif.KEY_VALID, kif.KEY_CODE);
        else n_pass++;
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        p0 = pulses;
        repeat (3) run_frame(16'(1) << 1);
        n_checks++;
        if (pulses - p0 !== 1 || kif.BCD !== 16'h0002)
            $display("FAIL rearm pulses=%0d bcd=%h exp 1/0002", pulses - p0, kif.BCD);
        else n_pass++;
        repeat (2) run_frame(16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int kind;
        repeat (40) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 7) mask = 16'(1) << $urandom_range(0, 15);
            else if (kind < 9) mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            else mask = 16'h0000;
            repeat ($urandom_range(1, 3)) run_frame(mask);
            repeat ($urandom_range(0, 3)) run_frame(16'h0000);
        end
        repeat (3) run_frame(16'h0000);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pulses   = 0;
        test_reset();
        test_single_press();
        test_digits();
        test_bounce();
        test_multi_key();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
